// File: rtl/option_fifo.sv
// Circular FIFO whose head is presented as an Option word {tag, payload}.
// Tag 0 is Some, tag 1 is None. None always carries a zero payload.
module option_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     _i_clk,
    input  logic                     _i_rst,
    input  logic [WIDTH-1:0]         _i_x,
    input  logic                     _i_valid,
    input  logic                     _i_pop,
    output logic [WIDTH:0]           __output,
    output logic                     _o_full,
    output logic [$clog2(DEPTH):0]   _o_count,
    output logic                     _o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [WIDTH-1:0] mem [DEPTH];

    logic full;
    logic empty;
    logic do_pop;
    logic do_push;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = _i_pop & ~empty;
    assign do_push = _i_valid & (~full | do_pop);

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (_i_valid && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is data only and is deliberately left out of reset.
    always_ff @(posedge _i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= _i_x;
        end
    end

    assign __output    = empty ? {1'b1, {WIDTH{1'b0}}} : {1'b0, mem[rd_ptr]};
    assign _o_full     = full;
    assign _o_count    = count;
    assign _o_overflow = overflow;

endmodule

// File: tb/tb_option_fifo.sv
// Randomised scoreboard bench for option_fifo against a queue-based Option model.
module tb_option_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] x;
    logic             valid;
    logic             pop;
    logic [WIDTH:0]   dout;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;

    option_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        ._i_clk     (clk),
        ._i_rst     (rst_n),
        ._i_x       (x),
        ._i_valid   (valid),
        ._i_pop     (pop),
        .__output   (dout),
        ._o_full    (full),
        ._o_count   (count),
        ._o_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH:0] out;
        logic           full;
        logic [CW-1:0]  cnt;
        logic           ovf;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_q[$];
    bit               model_ovf;
    int               vectors;
    int               miscompares;

    function automatic exp_t model_view();
        exp_t e;
        e.out  = (model_q.size() == 0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, model_q[0]};
        e.cnt  = CW'(model_q.size());
        e.full = (model_q.size() == DEPTH);
        e.ovf  = model_ovf;
        return e;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got out=%h full=%b count=%0d ovf=%b, want out=%h full=%b count=%0d ovf=%b",
                     name, got.out, got.full, got.cnt, got.ovf,
                     want.out, want.full, want.cnt, want.ovf);
        end
    endtask

    // Monitor: compares DUT state against the oldest expectation, away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t g;
            e = exp_q.pop_front();
            g = {dout, full, count, overflow};
            check("head", g, e);
        end
    end

    // One clock of stimulus; the model is updated from the Option/FIFO rules after the edge.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit p);
        bit pop_ok;
        bit push_ok;
        valid = v;
        x     = d;
        pop   = p;
        @(posedge clk);
        pop_ok  = p && (model_q.size() != 0);
        push_ok = v && ((model_q.size() < DEPTH) || pop_ok);
        if (pop_ok)  void'(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        else if (v)  model_ovf = 1'b1;
        exp_q.push_back(model_view());
        @(negedge clk);
        valid = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_q.delete();
            model_ovf = 1'b0;
            exp_q.push_back(model_view());
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t g;
        exp_t none_e;
        vectors     = 0;
        miscompares = 0;
        model_ovf   = 1'b0;
        rst_n = 1'b0;
        valid = 1'b0;
        pop   = 1'b0;
        x     = '0;
        none_e = '{out: {1'b1, {WIDTH{1'b0}}}, full: 1'b0, cnt: '0, ovf: 1'b0};

        reset_cycles(2);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // Single push then pop back to None
        cycle(1, 16'd123, 0);
        cycle(0, 0, 1);

        // Fill, overflow with no pop, then full push-with-pop
        cycle(1, 16'd10, 0);
        cycle(1, 16'd20, 0);
        cycle(1, 16'd30, 0);
        cycle(1, 16'd40, 0);
        cycle(1, 16'd99, 0);
        cycle(1, 16'd50, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);

        // Push into empty while popping; overflow stays sticky
        cycle(1, 16'd7, 1);
        cycle(0, 0, 1);

        reset_cycles(1);

        // Wrap-around through the pointers
        for (int i = 0; i < 10; i++) begin
            cycle(1, 16'(16'h0100 + i), 0);
            cycle(0, 0, 1);
        end

        // Randomised traffic, biased so full and empty are both reached
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 60), 16'($urandom), ($urandom_range(0, 99) < 45));
        end

        // Asynchronous reset between edges with three entries stored
        reset_cycles(1);
        cycle(1, 16'hA5A5, 0);
        cycle(1, 16'hFFFF, 0);
        cycle(1, 16'h0001, 0);
        #2 rst_n = 1'b0;
        #1;
        g = {dout, full, count, overflow};
        check("async_reset", g, none_e);
        reset_cycles(1);

        for (int i = 0; i < 100; i++) begin
            cycle(($urandom_range(0, 99) < 50), 16'($urandom), ($urandom_range(0, 99) < 50));
        end

        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/option_fifo.md
Name: option_fifo

Overview:
- Parametrised buffer that stores payloads and presents its head as an Option-encoded enum word: {tag, payload}.
- Tag 0 = Some (variant 0), tag 1 = None (variant 1), matching the compiler's enum layout.
- Generalises the single-cycle Option constructor to a configurable payload width and queue depth.
- Adds push/pop handshaking, occupancy reporting and overflow detection.
- Sits between a producer emitting valid-qualified values and a consumer that pattern-matches on Option.

Parameters:
- WIDTH, 16, payload width in bits; must be at least 1.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- _i_clk  input  1  clock; all state updates on the rising edge.
- _i_rst  input  1  reset; asynchronous, active-low.
- _i_x  input  WIDTH  payload to enqueue.
- _i_valid  input  1  push request for _i_x.
- _i_pop  input  1  consumer has taken the current head.
- __output  output  WIDTH+1  head as an Option: bit WIDTH is the tag, bits WIDTH-1..0 are the payload.
- _o_full  output  1  count == DEPTH.
- _o_count  output  $clog2(DEPTH)+1  number of stored entries.
- _o_overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - DEPTH x WIDTH storage array.
  - overflow register.
- Reset (_i_rst low, asynchronous assert, synchronous release):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Outputs during and after reset: __output = {1'b1, WIDTH'b0}, _o_full = 0, _o_count = 0, _o_overflow = 0.
  - Storage contents are not reset and are don't-care.
- Derived signals:
  - do_pop = _i_pop & (count != 0).
  - do_push = _i_valid & ((count != DEPTH) | do_pop).
  - A push into a full FIFO is accepted when a pop happens in the same cycle.
- Push: mem[wr_ptr] <= _i_x; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop: rd_ptr increments with the same wrap.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Output (combinational from registered state):
  - When count == 0: __output = {1'b1, WIDTH'b0}. None always carries a zero payload.
  - When count != 0: __output = {1'b0, mem[rd_ptr]}.
- Latency and bypass:
  - No bypass. A value pushed at edge N appears on __output after edge N when the FIFO was empty, i.e. one cycle of latency.
  - Pushing into an empty FIFO while _i_pop is high: the pop is ignored because count == 0; the push is stored.
- Pop when empty: ignored; pointers and count unchanged; no error flag.
- Push when full without a pop:
  - The data is dropped; mem, wr_ptr and count are unchanged.
  - overflow <= 1. It is sticky and cleared only by reset.
- _o_full and _o_count are decoded from the registered count; no extra latency.
- Reset asserted mid-operation: all state clears immediately without waiting for a clock edge; __output reads None in the same cycle.
- Ordering: strict FIFO. Payload bits pass through unmodified, with no sign or zero extension.

Test Plan:
- Reset then idle: hold _i_rst low 2 cycles, release, no stimulus -> __output = 17'h10000, _o_count = 0, _o_full = 0, _o_overflow = 0.
- Single push (WIDTH=16): _i_x = 123, _i_valid = 1 for 1 cycle -> next cycle __output = {1'b0, 16'd123}, _o_count = 1; pulse _i_pop -> __output[16] = 1, payload 0.
- Fill and order (DEPTH=4): push 10, 20, 30, 40 on consecutive cycles -> _o_full = 1, _o_count = 4; pop 4 times -> heads 10, 20, 30, 40 in order, then None.
- Overflow: with the FIFO full, push 99 with no pop -> _o_overflow = 1, _o_count stays 4, head still 10; flag persists after draining until reset.
- Simultaneous push and pop:
  - Full FIFO, push 50 with pop -> count stays 4, no overflow, drain order 20, 30, 40, 50.
  - Empty FIFO, push 7 with pop -> count = 1, head = 7.
- Wrap-around and async reset: push and pop 10 values through DEPTH=4 checking each head; then assert _i_rst low between clock edges while count = 3 -> __output reads None and _o_count = 0 before the next edge.
